// File: rtl/load_store_unit_if.sv
// Signal bundle between the load/store unit, the core memory port and the
// word-wide data bus. The unit attaches through the slave modport. The
// environment (core plus bus responder) attaches through the master modport.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  busy;

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [31:0]           bus_wdata;
    logic                  bus_ack;
    logic [31:0]           bus_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  bus_ack, bus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output bus_ack, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I memory access into one or two word bus
// transactions, then returns extended load data with a one-cycle response.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; req_ready high, busy low
// ACC0  | first (or only) bus word, waiting for bus_ack
// ACC1  | second word of an access that crosses a word boundary
// RESP  | resp_valid pulse; busy still high, no new request taken
module load_store_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave lsu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Lanes of the first word: mask shifted up by the byte offset.
    function automatic logic [3:0] be_first(input logic [3:0] mask, input logic [1:0] off);
        logic [7:0] m;
        m = {4'b0000, mask} << off;
        return m[3:0];
    endfunction

    // Lanes of the second word: the bytes that spilled past lane 3.
    function automatic logic [3:0] be_second(input logic [3:0] mask, input logic [1:0] off);
        logic [2:0] sh;
        sh = 3'd4 - {1'b0, off};
        return mask >> sh;
    endfunction

    function automatic logic [31:0] wd_first(input logic [31:0] wd, input logic [1:0] off);
        logic [63:0] t;
        t = {32'h0, wd} << {off, 3'b000};
        return t[31:0];
    endfunction

    function automatic logic [31:0] wd_second(input logic [31:0] wd, input logic [1:0] off);
        logic [5:0] sh;
        sh = {3'd4 - {1'b0, off}, 3'b000};
        return wd >> sh;
    endfunction

    // pair = {hi word, lo word}; pick the addressed bytes, then extend.
    function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [63:0] t;
        logic [31:0] raw;
        logic [31:0] res;
        t   = pair >> {off, 3'b000};
        raw = t[31:0];
        case (f3[1:0])
            2'd0:    res = f3[2] ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
            2'd1:    res = f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;
    logic                  cross_q, cross_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           lo_q, lo_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic [3:0]            req_mask;
    logic [1:0]            req_off;
    logic                  req_cross;
    logic                  req_illegal;
    logic [3:0]            cur_mask;

    // Next-state and next-output logic; every bus/resp output is registered.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        cross_d      = cross_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        req_mask    = size_mask(lsu.req_funct3[1:0]);
        req_off     = lsu.req_addr[1:0];
        req_cross   = ({1'b0, req_off} + size_bytes(lsu.req_funct3[1:0])) > 3'd4;
        req_illegal = (lsu.req_funct3[1:0] == 2'b11);
        cur_mask    = size_mask(funct3_q[1:0]);

        case (state_q)
            IDLE: begin
                if (lsu.req_valid) begin
                    write_d  = lsu.req_write;
                    funct3_d = lsu.req_funct3;
                    offset_d = req_off;
                    cross_d  = req_cross;
                    wdata_d  = lsu.req_wdata;
                    lo_d     = 32'h0;
                    if (req_illegal || (req_cross && !ALLOW_MISALIGNED)) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACC0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = lsu.req_write;
                        bus_addr_d  = {lsu.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_d    = be_first(req_mask, req_off);
                        bus_wdata_d = wd_first(lsu.req_wdata, req_off);
                    end
                end
            end
            ACC0: begin
                if (lsu.bus_ack) begin
                    lo_d = lsu.bus_rdata;
                    if (cross_q) begin
                        state_d     = ACC1;
                        bus_addr_d  = bus_addr_q + ADDR_WIDTH'(4);
                        bus_be_d    = be_second(cur_mask, offset_q);
                        bus_wdata_d = wd_second(wdata_q, offset_q);
                    end else begin
                        state_d      = RESP;
                        bus_req_d    = 1'b0;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = write_q ? 32'h0
                                     : load_extend({32'h0, lsu.bus_rdata}, offset_q, funct3_q);
                    end
                end
            end
            ACC1: begin
                if (lsu.bus_ack) begin
                    state_d      = RESP;
                    bus_req_d    = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = write_q ? 32'h0
                                 : load_extend({lsu.bus_rdata, lo_q}, offset_q, funct3_q);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resp_valid_d = (state_d == RESP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            offset_q     <= 2'd0;
            cross_q      <= 1'b0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'h0;
            bus_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            cross_q      <= cross_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign lsu.req_ready  = (state_q == IDLE);
    assign lsu.busy       = (state_q != IDLE);
    assign lsu.resp_valid = resp_valid_q;
    assign lsu.resp_rdata = resp_rdata_q;
    assign lsu.resp_err   = resp_err_q;
    assign lsu.bus_req    = bus_req_q;
    assign lsu.bus_we     = bus_we_q;
    assign lsu.bus_addr   = bus_addr_q;
    assign lsu.bus_be     = bus_be_q;
    assign lsu.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with misaligned splitting
// enabled and a word-memory responder, one with it disabled and a silent bus.
module tb_load_store_unit;

    logic clk;
    logic rst;

    load_store_unit_if #(.ADDR_WIDTH(32)) if_a ();
    load_store_unit_if #(.ADDR_WIDTH(32)) if_b ();

    load_store_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .lsu (if_a.slave)
    );

    load_store_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .lsu (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Word memory responder with programmable wait states; logs each acked transaction.
    logic [31:0] mem [logic [31:0]];
    int          wait_cfg  = 0;
    int          wcnt      = 0;
    logic        force_ack = 1'b0;
    logic [31:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic        log_we[$];
    logic [31:0] log_wd[$];
    int          b_req_cnt = 0;

    always @(negedge clk) begin
        if (force_ack) begin
            if_a.bus_ack   = 1'b1;
            if_a.bus_rdata = 32'h5555_5555;
        end else if (if_a.bus_req) begin
            if (wcnt >= wait_cfg) begin
                if_a.bus_ack   = 1'b1;
                if_a.bus_rdata = mem.exists(if_a.bus_addr) ? mem[if_a.bus_addr] : 32'h0;
                log_addr.push_back(if_a.bus_addr);
                log_be.push_back(if_a.bus_be);
                log_we.push_back(if_a.bus_we);
                log_wd.push_back(if_a.bus_wdata);
                wcnt = 0;
            end else begin
                if_a.bus_ack = 1'b0;
                wcnt++;
            end
        end else begin
            if_a.bus_ack = 1'b0;
            wcnt = 0;
        end
        if (if_b.bus_req) b_req_cnt++;
    end

    task automatic clear_log();
        log_addr.delete();
        log_be.delete();
        log_we.delete();
        log_wd.delete();
    endtask

    // Issue one request on instance A; lat counts cycles from the accept cycle (0).
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rdata, output logic err);
        @(negedge clk);
        check_val("req_ready_before", 32'(if_a.req_ready), 32'd1);
        clear_log();
        if_a.req_valid  = 1'b1;
        if_a.req_write  = wr;
        if_a.req_funct3 = f3;
        if_a.req_addr   = addr;
        if_a.req_wdata  = wd;
        lat   = 0;
        rdata = 32'hx;
        err   = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) if_a.req_valid = 1'b0;
            if (if_a.resp_valid) begin
                lat   = i;
                rdata = if_a.resp_rdata;
                err   = if_a.resp_err;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.req_valid = 1'b0; if_a.req_write = 1'b0; if_a.req_funct3 = 3'd0;
        if_a.req_addr = 32'h0; if_a.req_wdata = 32'h0;
        if_a.bus_ack = 1'b0; if_a.bus_rdata = 32'h0;
        if_b.req_valid = 1'b0; if_b.req_write = 1'b0; if_b.req_funct3 = 3'd0;
        if_b.req_addr = 32'h0; if_b.req_wdata = 32'h0;
        if_b.bus_ack = 1'b0; if_b.bus_rdata = 32'h0;
        rst = 1'b1;

        mem[32'h0000_0100] = 32'hDEAD_BEEF;
        mem[32'h0000_01FC] = 32'h3344_5566;
        mem[32'h0000_0200] = 32'h7788_1122;
        mem[32'h0000_0300] = 32'h8001_7FFF;
        mem[32'h0000_0400] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check_val("rst_req_ready",  32'(if_a.req_ready),  32'd1);
        check_val("rst_busy",       32'(if_a.busy),       32'd0);
        check_val("rst_resp_valid", 32'(if_a.resp_valid), 32'd0);
        check_val("rst_resp_rdata", if_a.resp_rdata,      32'h0);
        check_val("rst_resp_err",   32'(if_a.resp_err),   32'd0);
        check_val("rst_bus_req",    32'(if_a.bus_req),    32'd0);
        check_val("rst_bus_addr",   if_a.bus_addr,        32'h0);
        check_val("rst_bus_be",     32'(if_a.bus_be),     32'h0);
        check_val("rst_bus_wdata",  if_a.bus_wdata,       32'h0);
        rst = 1'b0;

        // Aligned LW, zero wait
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, rd, er);
        check_val("lw_lat",   32'(lat), 32'd2);
        check_val("lw_rdata", rd, 32'hDEAD_BEEF);
        check_val("lw_err",   32'(er), 32'd0);
        check_val("lw_ntx",   32'(log_addr.size()), 32'd1);
        check_val("lw_addr",  log_addr[0], 32'h0000_0100);
        check_val("lw_be",    32'(log_be[0]), 32'hF);
        check_val("lw_we",    32'(log_we[0]), 32'd0);
        @(negedge clk);
        check_val("lw_pulse", 32'(if_a.resp_valid), 32'd0);
        check_val("lw_hold",  if_a.resp_rdata, 32'hDEAD_BEEF);
        check_val("lw_bus_req_drop", 32'(if_a.bus_req), 32'd0);

        // Aligned LW with two wait states
        wait_cfg = 2;
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, rd, er);
        check_val("lw_wait_lat",   32'(lat), 32'd4);
        check_val("lw_wait_rdata", rd, 32'hDEAD_BEEF);
        wait_cfg = 0;

        // LB / LBU at byte 3
        mem[32'h0000_0100] = 32'h8011_2233;
        do_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, lat, rd, er);
        check_val("lb_rdata", rd, 32'hFFFF_FF80);
        check_val("lb_be",    32'(log_be[0]), 32'h8);
        check_val("lb_addr",  log_addr[0], 32'h0000_0100);
        do_req(1'b0, 3'b100, 32'h0000_0103, 32'h0, lat, rd, er);
        check_val("lbu_rdata", rd, 32'h0000_0080);

        // LH / LHU at byte 2
        do_req(1'b0, 3'b001, 32'h0000_0302, 32'h0, lat, rd, er);
        check_val("lh_rdata", rd, 32'hFFFF_8001);
        check_val("lh_be",    32'(log_be[0]), 32'hC);
        do_req(1'b0, 3'b101, 32'h0000_0302, 32'h0, lat, rd, er);
        check_val("lhu_rdata", rd, 32'h0000_8001);

        // SH at byte 2
        do_req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, lat, rd, er);
        check_val("sh_lat",   32'(lat), 32'd2);
        check_val("sh_we",    32'(log_we[0]), 32'd1);
        check_val("sh_be",    32'(log_be[0]), 32'hC);
        check_val("sh_wdata", log_wd[0], 32'hABCD_0000);
        check_val("sh_addr",  log_addr[0], 32'h0000_0200);
        check_val("sh_rdata", rd, 32'h0);

        // Misaligned LW split across 0x1FC / 0x200
        do_req(1'b0, 3'b010, 32'h0000_01FE, 32'h0, lat, rd, er);
        check_val("mlw_lat",   32'(lat), 32'd3);
        check_val("mlw_ntx",   32'(log_addr.size()), 32'd2);
        check_val("mlw_addr0", log_addr[0], 32'h0000_01FC);
        check_val("mlw_be0",   32'(log_be[0]), 32'hC);
        check_val("mlw_addr1", log_addr[1], 32'h0000_0200);
        check_val("mlw_be1",   32'(log_be[1]), 32'h3);
        check_val("mlw_rdata", rd, 32'h1122_3344);
        check_val("mlw_err",   32'(er), 32'd0);

        // Misaligned SW wrapping past the top of the address space
        do_req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hA1B2_C3D4, lat, rd, er);
        check_val("msw_lat",   32'(lat), 32'd3);
        check_val("msw_addr0", log_addr[0], 32'hFFFF_FFFC);
        check_val("msw_be0",   32'(log_be[0]), 32'h8);
        check_val("msw_wd0",   log_wd[0], 32'hD400_0000);
        check_val("msw_addr1", log_addr[1], 32'h0000_0000);
        check_val("msw_be1",   32'(log_be[1]), 32'h7);
        check_val("msw_wd1",   log_wd[1], 32'h00A1_B2C3);
        check_val("msw_we1",   32'(log_we[1]), 32'd1);
        check_val("msw_rdata", rd, 32'h0);

        // Illegal size
        do_req(1'b0, 3'b011, 32'h0000_0100, 32'h0, lat, rd, er);
        check_val("ill_lat",   32'(lat), 32'd1);
        check_val("ill_err",   32'(er), 32'd1);
        check_val("ill_rdata", rd, 32'h0);
        check_val("ill_ntx",   32'(log_addr.size()), 32'd0);
        @(negedge clk);
        check_val("ill_err_hold", 32'(if_a.resp_err), 32'd1);
        check_val("ill_pulse",    32'(if_a.resp_valid), 32'd0);

        // Misaligned SW on the instance that rejects misalignment
        @(negedge clk);
        b_req_cnt = 0;
        if_b.req_valid  = 1'b1;
        if_b.req_write  = 1'b1;
        if_b.req_funct3 = 3'b010;
        if_b.req_addr   = 32'hFFFF_FFFF;
        if_b.req_wdata  = 32'hA1B2_C3D4;
        @(negedge clk);
        if_b.req_valid = 1'b0;
        check_val("nomis_resp_valid", 32'(if_b.resp_valid), 32'd1);
        check_val("nomis_err",        32'(if_b.resp_err), 32'd1);
        repeat (3) @(negedge clk);
        check_val("nomis_no_bus", 32'(b_req_cnt), 32'd0);

        // Reset during a wait-stated LW, then a late ack
        wait_cfg = 5;
        @(negedge clk);
        if_a.req_valid  = 1'b1;
        if_a.req_write  = 1'b0;
        if_a.req_funct3 = 3'b010;
        if_a.req_addr   = 32'h0000_0400;
        @(negedge clk);
        if_a.req_valid = 1'b0;
        check_val("rw_bus_req", 32'(if_a.bus_req), 32'd1);
        check_val("rw_addr1",   if_a.bus_addr, 32'h0000_0400);
        @(negedge clk);
        check_val("rw_addr2", if_a.bus_addr, 32'h0000_0400);
        check_val("rw_be2",   32'(if_a.bus_be), 32'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rw_bus_req_off", 32'(if_a.bus_req), 32'd0);
        check_val("rw_busy",        32'(if_a.busy), 32'd0);
        check_val("rw_ready",       32'(if_a.req_ready), 32'd1);
        force_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) force_ack = 1'b0;
            if (if_a.resp_valid || if_a.busy || if_a.bus_req) seen = 1'b1;
        end
        check_val("rw_late_ack_ignored", 32'(seen), 32'd0);
        wait_cfg = 0;

        // Normal access after the reset
        mem[32'h0000_0100] = 32'hDEAD_BEEF;
        do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, rd, er);
        check_val("post_rst_lat",   32'(lat), 32'd2);
        check_val("post_rst_rdata", rd, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage between the RV32I core's memory port (address, store data, funct3, write strobe) and a word-wide, handshaked data bus.
- Generates byte enables and positions store data for SB/SH/SW.
- Splits misaligned accesses into two word transactions.
- Realigns and sign- or zero-extends load data for LB/LH/LW/LBU/LHU.
- Presents a stall (busy) to the core until the response is delivered.

Parameters:
ADDR_WIDTH, 32, width of core and bus byte addresses
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two bus cycles; 0 = flag err with no bus access

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  core requests an access this cycle
req_ready  output  1  unit idle, accepts request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  32  extended load data (0 for stores or err)
resp_err  output  1  qualified by resp_valid: illegal size or disallowed misalignment
busy  output  1  stall to core; high whenever not IDLE
bus_req  output  1  bus transaction request
bus_we  output  1  bus write
bus_addr  output  ADDR_WIDTH  word-aligned address, low 2 bits always 0
bus_be  output  4  byte enables
bus_wdata  output  32  lane-positioned store data
bus_ack  input  1  bus completes current transaction this cycle
bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; req_ready=1; busy=0; resp_valid=0; resp_rdata=0; resp_err=0; bus_req=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0.
- Size from funct3[1:0]: 0 = byte (mask 0001), 1 = half (0011), 2 = word (1111). Value 3 is illegal. funct3[2] selects zero-extend for loads and is ignored for stores.
- offset = addr[1:0]. cross = (offset + size_bytes > 4).
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - Request is accepted when req_valid=1; req_valid is ignored otherwise.
  - On accept, latch write, funct3, addr and wdata.
  - Illegal size, or cross with ALLOW_MISALIGNED=0, goes to RESP with err=1 and issues no bus access.
  - Every other accepted request goes to ACC0.
- ACC0:
  - bus_req=1; bus_we=write; bus_addr={addr[ADDR_WIDTH-1:2],00}.
  - bus_be = (mask<<offset)[3:0]; bus_wdata = (wdata<<8*offset)[31:0].
  - On bus_ack: capture bus_rdata as lo, then go to ACC1 if cross, else RESP.
- ACC1:
  - bus_addr = word address of ACC0 + 4, wrapping modulo 2^ADDR_WIDTH.
  - bus_be = mask>>(4-offset); bus_wdata = wdata>>8*(4-offset).
  - On bus_ack: capture bus_rdata as hi, then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE. busy stays high in RESP.
  - Loads: raw = ({hi,lo}>>8*offset)[31:0], then sign-extend from bit 7/15 (LB/LH), zero-extend (LBU/LHU), or pass through (LW).
  - Stores: resp_rdata=0.
  - resp_rdata and resp_err hold their values until the next RESP.
- Bus rules:
  - bus_addr, bus_be, bus_we and bus_wdata are stable while bus_req=1 and bus_ack=0.
  - bus_req drops in the cycle after the final ack.
  - bus_ack outside ACC0/ACC1 is ignored.
  - Unlimited wait states.
- Latency, zero-wait bus, measured from the accept edge: aligned access resp_valid at +2 cycles; split access at +3; err at +1.
- Back-to-back: req_ready=0 during RESP, so the next request is accepted no earlier than the cycle after resp_valid.
- Reset mid-operation: the next edge forces IDLE and bus_req=0, discards any captured data, and emits no resp_valid. A late bus_ack after reset is ignored.
- Registered outputs: bus_* and resp_* are registered, with no combinational path from req_* to bus_*.

Test Plan:
- Aligned LW, addr 0x100, bus_rdata 0xDEADBEEF, zero-wait -> bus_addr 0x100, be 1111, resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- LB vs LBU, addr 0x103, rdata 0x80112233 -> be 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH, addr 0x202, wdata 0x0000ABCD -> bus_we 1, be 1100, bus_wdata 0xABCD0000, resp_rdata 0.
- Misaligned LW, addr 0x1FE, word 0x1FC = 0x3344xxxx, word 0x200 = 0xxxxx1122 -> two transactions (be 1100, then be 0011 at 0x200), rdata 0x11223344, resp at +3.
- Misaligned SW, addr 0xFFFFFFFF -> first word: be 1000 at 0xFFFFFFFC; second word: be 0111 at 0x00000000 (wrap). With ALLOW_MISALIGNED=0: err 1, no bus_req.
- funct3 = 011 -> err 1 at +1, no bus_req. Separately: LW with 5 ack wait states, rst raised in wait cycle 3 -> IDLE next edge, no resp_valid, late ack ignored.
